// File: rtl/vga_pong_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pong_renderer
//  Description : Pong pixel generator behind a 640x480 VGA timing controller.
//                Draws a left wall, a button-driven paddle and a bouncing
//                ball. Game state advances once per frame at the start of
//                vertical blank. RGB and syncs are registered on p_tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pong_renderer #(
    parameter int HD      = 640,
    parameter int VD      = 480,
    parameter int WALL_X0 = 32,
    parameter int WALL_X1 = 39,
    parameter int PAD_X0  = 600,
    parameter int PAD_X1  = 603,
    parameter int PAD_H   = 72,
    parameter int PAD_V   = 3,
    parameter int BALL_SZ = 8,
    parameter int BALL_V  = 2
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        btn_up,
    input  logic        btn_dn,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick,
    output logic [7:0]  hit_count,
    output logic [3:0]  miss_count
);

    // 11-bit copies of the geometry so sums never overflow
    localparam logic [10:0] c_hd         = 11'(HD);
    localparam logic [10:0] c_vd         = 11'(VD);
    localparam logic [10:0] c_wall_x0    = 11'(WALL_X0);
    localparam logic [10:0] c_wall_x1    = 11'(WALL_X1);
    localparam logic [10:0] c_pad_x0     = 11'(PAD_X0);
    localparam logic [10:0] c_pad_x1     = 11'(PAD_X1);
    localparam logic [10:0] c_pad_h      = 11'(PAD_H);
    localparam logic [10:0] c_pad_v      = 11'(PAD_V);
    localparam logic [10:0] c_ball_sz    = 11'(BALL_SZ);
    localparam logic [10:0] c_ball_v     = 11'(BALL_V);
    localparam logic [10:0] c_ball_y_max = c_vd - c_ball_sz;
    localparam logic [10:0] c_pad_y_max  = c_vd - c_pad_h;
    // Centred start positions: ball (316,236), paddle top 204
    localparam logic [9:0]  c_ball_x_rst = 10'((HD - BALL_SZ) / 2);
    localparam logic [9:0]  c_ball_y_rst = 10'((VD - BALL_SZ) / 2);
    localparam logic [9:0]  c_pad_y_rst  = 10'((VD - PAD_H) / 2);

    localparam logic [11:0] c_col_black = 12'h000;
    localparam logic [11:0] c_col_ball  = 12'hF00;
    localparam logic [11:0] c_col_pad   = 12'h0F0;
    localparam logic [11:0] c_col_wall  = 12'h00F;
    localparam logic [11:0] c_col_bg    = 12'hFFF;

    logic        r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
    logic        r_frame_tick;
    logic [9:0]  r_ball_x, r_ball_y, r_pad_y;
    logic        r_dx_pos, r_dy_pos;
    logic [7:0]  r_hit_count;
    logic [3:0]  r_miss_count;
    logic [11:0] r_rgb;
    logic        r_hsync, r_vsync;

    logic [10:0] w_bx, w_by, w_pad, w_x, w_y;
    logic        w_miss, w_pad_rows, w_pad_hit, w_wall_hit, w_top, w_bot;
    logic [9:0]  w_ball_x_nxt, w_ball_y_nxt, w_pad_y_nxt;
    logic [9:0]  w_bx_mv, w_by_mv;
    logic [10:0] w_pad_dn;
    logic        w_dx_nxt, w_dy_nxt;
    logic [7:0]  w_hit_nxt;
    logic [3:0]  w_miss_nxt;
    logic        w_in_ball, w_in_pad, w_in_wall;
    logic [11:0] w_rgb;

    assign w_bx  = {1'b0, r_ball_x};
    assign w_by  = {1'b0, r_ball_y};
    assign w_pad = {1'b0, r_pad_y};
    assign w_x   = {1'b0, x};
    assign w_y   = {1'b0, y};

    // Collision predicates on the pre-update ball and paddle positions
    assign w_miss     = w_bx > (c_hd - c_ball_sz);
    assign w_pad_rows = (w_by <= w_pad + c_pad_h - 11'd1) &&
                        (w_by + c_ball_sz - 11'd1 >= w_pad);
    assign w_pad_hit  = r_dx_pos && (w_bx + c_ball_sz - 11'd1 >= c_pad_x0) &&
                        (w_bx <= c_pad_x1) && w_pad_rows;
    assign w_wall_hit = w_bx <= c_wall_x1 + 11'd1;
    assign w_top      = w_by <= c_ball_v;
    assign w_bot      = w_by + c_ball_sz >= c_vd - c_ball_v;

    // Resolve bounces in priority order, then step the ball
    always_comb begin
        w_ball_x_nxt = r_ball_x;
        w_ball_y_nxt = r_ball_y;
        w_dx_nxt     = r_dx_pos;
        w_dy_nxt     = r_dy_pos;
        w_hit_nxt    = r_hit_count;
        w_miss_nxt   = r_miss_count;
        w_bx_mv      = r_ball_x;
        w_by_mv      = r_ball_y;
        if (w_miss) begin
            w_ball_x_nxt = c_ball_x_rst;
            w_ball_y_nxt = c_ball_y_rst;
            w_dx_nxt     = 1'b0;
            if (r_miss_count != 4'hF) begin
                w_miss_nxt = r_miss_count + 4'd1;
            end
        end else begin
            if (w_pad_hit) begin
                w_dx_nxt  = 1'b0;
                w_hit_nxt = r_hit_count + 8'd1;
            end else if (w_wall_hit) begin
                w_dx_nxt = 1'b1;
            end
            if (w_top) begin
                w_dy_nxt = 1'b1;
            end else if (w_bot) begin
                w_dy_nxt = 1'b0;
            end
            if (w_dx_nxt) begin
                w_bx_mv = 10'(w_bx + c_ball_v);
            end else if (w_bx >= c_ball_v) begin
                w_bx_mv = 10'(w_bx - c_ball_v);
            end else begin
                w_bx_mv = '0;
            end
            if (w_dy_nxt) begin
                w_by_mv = 10'(w_by + c_ball_v);
            end else if (w_by >= c_ball_v) begin
                w_by_mv = 10'(w_by - c_ball_v);
            end else begin
                w_by_mv = '0;
            end
            if ({1'b0, w_by_mv} > c_ball_y_max) begin
                w_by_mv = c_ball_y_max[9:0];
            end
            w_ball_x_nxt = w_bx_mv;
            w_ball_y_nxt = w_by_mv;
        end
    end

    // Paddle step: exactly one button moves it, clamped to the screen
    always_comb begin
        w_pad_y_nxt = r_pad_y;
        w_pad_dn    = w_pad + c_pad_v;
        if (r_up_s2 && !r_dn_s2) begin
            if (w_pad >= c_pad_v) begin
                w_pad_y_nxt = 10'(w_pad - c_pad_v);
            end else begin
                w_pad_y_nxt = '0;
            end
        end else if (r_dn_s2 && !r_up_s2) begin
            if (w_pad_dn > c_pad_y_max) begin
                w_pad_y_nxt = c_pad_y_max[9:0];
            end else begin
                w_pad_y_nxt = w_pad_dn[9:0];
            end
        end
    end

    // Object membership of the current pixel and colour priority
    assign w_in_ball = (w_x >= w_bx) && (w_x < w_bx + c_ball_sz) &&
                       (w_y >= w_by) && (w_y < w_by + c_ball_sz);
    assign w_in_pad  = (w_x >= c_pad_x0) && (w_x <= c_pad_x1) &&
                       (w_y >= w_pad) && (w_y < w_pad + c_pad_h);
    assign w_in_wall = (w_x >= c_wall_x0) && (w_x <= c_wall_x1);

    // Pick the pixel colour; blanking wins over every object
    always_comb begin
        w_rgb = c_col_bg;
        if (!video_on) begin
            w_rgb = c_col_black;
        end else if (w_in_ball) begin
            w_rgb = c_col_ball;
        end else if (w_in_pad) begin
            w_rgb = c_col_pad;
        end else if (w_in_wall) begin
            w_rgb = c_col_wall;
        end
    end

    // Two-flop synchronisers for the asynchronous push-buttons
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_up_s1 <= 1'b0;
            r_up_s2 <= 1'b0;
            r_dn_s1 <= 1'b0;
            r_dn_s2 <= 1'b0;
        end else begin
            r_up_s1 <= btn_up;
            r_up_s2 <= r_up_s1;
            r_dn_s1 <= btn_dn;
            r_dn_s2 <= r_dn_s1;
        end
    end

    // Game state advances only on the once-per-frame tick
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_ball_x     <= c_ball_x_rst;
            r_ball_y     <= c_ball_y_rst;
            r_dx_pos     <= 1'b1;
            r_dy_pos     <= 1'b1;
            r_pad_y      <= c_pad_y_rst;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_frame_tick) begin
            r_ball_x     <= w_ball_x_nxt;
            r_ball_y     <= w_ball_y_nxt;
            r_dx_pos     <= w_dx_nxt;
            r_dy_pos     <= w_dy_nxt;
            r_pad_y      <= w_pad_y_nxt;
            r_hit_count  <= w_hit_nxt;
            r_miss_count <= w_miss_nxt;
        end
    end

    // Pixel pipeline: colour and syncs share one p_tick-enabled stage
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_rgb        <= '0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= p_tick && (w_x == 11'd0) && (w_y == c_vd);
            if (p_tick) begin
                r_rgb   <= w_rgb;
                r_hsync <= hsync_in;
                r_vsync <= vsync_in;
            end
        end
    end

    assign rgb        = r_rgb;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = r_frame_tick;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire
